// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial adder/subtractor. One operand set is accepted through a
// valid/ready handshake. The operands are processed one bit per clock, LSB
// first, through a single full-adder cell. The result is then presented
// through a second valid/ready handshake.
//
// Subtraction is done as a + ~b + 1. The operand b is inverted at capture and
// the carry is seeded with 1. For subtraction, cout = 1 means no borrow.
//
// Optional feature macro: SERIAL_ADDSUB_OVF_EN
//   When defined, the ovf port and its capture logic are present. ovf is the
//   signed overflow flag: carry into the MSB XOR carry out of the MSB.
//   When undefined, the port and its registers are omitted. All other
//   behaviour is identical.
//
// Parameters
//   WIDTH      operand/result width in bits (2..32)
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand set valid
//   in_ready   block can accept an operand set (IDLE only)
//   a, b       operands
//   sub        0 = a+b, 1 = a-b
//   out_valid  result valid (DONE only)
//   out_ready  downstream accepts the result
//   result     sum/difference modulo 2^WIDTH
//   cout       final carry out
//   ovf        signed overflow (only with SERIAL_ADDSUB_OVF_EN)
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    // Working registers for the serial datapath
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_count;

    // Presented outputs. They are kept separate from the shift register so
    // that they hold their last values while a new operation runs.
    logic [WIDTH-1:0] r_result;
    logic             r_cout;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic             r_ovf_pend;
    logic             r_ovf;
`endif

    // Control strobes decoded by the FSM
    logic             w_accept;
    logic             w_shift;
    logic             w_finish;

    // Full-adder cell
    logic             w_sum_bit;
    logic             w_carry_next;
    logic             w_last_bit;

    assign w_sum_bit    = r_opa[0] ^ r_opb[0] ^ r_carry;
    assign w_carry_next = (r_opa[0] & r_opb[0]) |
                          (r_opa[0] & r_carry)  |
                          (r_opb[0] & r_carry);
    assign w_last_bit   = (r_count == CW'(WIDTH - 1));

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and decoded outputs
    //
    // RUN processes one bit per cycle while the counter is below WIDTH. The
    // cycle in which the counter reads WIDTH copies the finished word into
    // the output registers and moves to DONE. This gives a fixed latency of
    // WIDTH+1 edges from the accepting edge to out_valid.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        w_finish     = 1'b0;

        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end

            RUN: begin
                if (r_count == CW'(WIDTH)) begin
                    w_finish     = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_shift = 1'b1;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Serial datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opa   <= a;
                r_opb   <= b ^ {WIDTH{sub}};
                r_carry <= sub;
                r_count <= '0;
            end

            if (w_shift) begin
                r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
                r_opa   <= r_opa >> 1;
                r_opb   <= r_opb >> 1;
                r_carry <= w_carry_next;
                r_count <= r_count + CW'(1);
            end

            if (w_finish) begin
                r_result <= r_sum;
                r_cout   <= r_carry;
            end
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // On the MSB cycle, r_carry is the carry into the MSB and w_carry_next is
    // the carry out of it. The flag is staged and then published together
    // with the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_pend <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_shift && w_last_bit) begin
                r_ovf_pend <= r_carry ^ w_carry_next;
            end
            if (w_finish) begin
                r_ovf <= r_ovf_pend;
            end
        end
    end

    assign ovf = r_ovf;
`endif

    assign result = r_result;
    assign cout   = r_cout;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: unsigned sum or difference, borrow as a compare,
    // and overflow from the signed result range.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                  output logic [W-1:0] r, output logic c, output logic o);
        longint m  = longint'(1) << W;
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = x[W-1] ? ux - m : ux;
        longint sy = y[W-1] ? uy - m : uy;
        longint full;
        longint sr;
        if (s) begin
            full = ux - uy;
            c    = (ux >= uy);
            sr   = sx - sy;
        end else begin
            full = ux + uy;
            c    = (full >= m);
            sr   = sx + sy;
        end
        r = full[W-1:0];
        o = (sr > (m / 2) - 1) || (sr < -(m / 2));
    endfunction

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                          input int hold, input string tag);
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        int           n;
        int           lat;
        n = 0;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        model(xa, xb, xs, er, ec, eo);
        a = xa;
        b = xb;
        sub = xs;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        // Garbage on the inputs and a random out_ready while the operation runs
        while (!out_valid && lat < 20) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
            sub       = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'(W + 1));
        chk({tag, ".result"}, 32'(result), 32'(er));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDSUB_OVF_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
`endif
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_result"}, 32'(result), 32'(er));
            chk({tag, ".hold_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDSUB_OVF_EN
            chk({tag, ".hold_ovf"}, 32'(ovf), 32'(eo));
`endif
        end
        chk({tag, ".no_bypass"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".ready_rise"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.result", 32'(result), 32'd0);
        chk("reset.cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("reset.ovf", 32'(ovf), 32'd0);
`endif

        run_op(8'h7F, 8'h01, 1'b0, 0, "add_ovf");
        run_op(8'hFF, 8'h01, 1'b0, 1, "add_wrap");
        run_op(8'h10, 8'h20, 1'b1, 0, "sub_borrow");
        run_op(8'h80, 8'h01, 1'b1, 2, "sub_ovf");
        run_op(8'h5A, 8'h33, 1'b0, 5, "hold5");

        // Reset during the third RUN cycle
        a = 8'h12;
        b = 8'h34;
        sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        chk("midrst.result", 32'(result), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("midrst.no_partial", 32'(seen), 32'd0);
        run_op(8'h35, 8'h4A, 1'b0, 0, "after_rst");

        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), "random");
        end

        run_op(8'h00, 8'h00, 1'b1, 0, "sub_zero");
        run_op(8'h80, 8'h80, 1'b0, 0, "add_negneg");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand set valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand set.
REQ-006 SHALL have port a  input  WIDTH  first operand.
REQ-007 SHALL have port b  input  WIDTH  second operand.
REQ-008 SHALL have port sub  input  1  operation select; 0 = a+b, 1 = a-b.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-012 SHALL have port cout  output  1  final carry out; for subtract, 1 = no borrow.
REQ-013 SHALL have port ovf  output  1  signed two's-complement overflow; present only with SERIAL_ADDSUB_OVF_EN.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL drive out_valid=1 only in DONE.
REQ-017 SHALL, on an IDLE edge with in_valid=1, capture a, (b XOR {WIDTH{sub}}) and carry=sub, clear the bit counter, and enter RUN.
REQ-018 SHALL ignore a, b, sub and in_valid outside IDLE.
REQ-019 SHALL, each RUN cycle, process one bit LSB-first through one full-adder cell: sum = a0^b0^c; c' = majority(a0,b0,c).
REQ-020 SHALL shift the sum bit into the result register at its MSB and shift both operand registers right by one, each RUN cycle.
REQ-021 SHALL increment the bit counter each RUN cycle; counter width SHALL be clog2(WIDTH+1).
REQ-022 SHALL leave RUN for DONE after exactly WIDTH RUN cycles.
REQ-023 SHALL assert out_valid on the (WIDTH+1)th rising edge after the accepting edge, fixed regardless of data.
REQ-024 SHALL hold result, cout and ovf stable in DONE until an edge with out_ready=1.
REQ-025 SHALL go DONE -> IDLE on that edge; in_ready rises on the following cycle, with no same-cycle bypass.
REQ-026 SHALL ignore out_ready while out_valid=0.
REQ-027 SHALL hold result, cout and ovf at their last values in IDLE and RUN; these outputs are only meaningful while out_valid=1.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter IDLE with result=0, cout=0, ovf=0, carry=0, counter=0, out_valid=0; in_ready=1 in the next cycle.
REQ-029 SHALL, on reset during RUN or DONE, discard the in-flight operation with no partial result ever presented.
REQ-030 SHALL give rst priority over all handshakes in the same cycle.

Configuration
REQ-031 SHALL, with macro SERIAL_ADDSUB_OVF_EN defined, include port ovf and a register capturing carry-into-MSB XOR carry-out-of-MSB on the final RUN cycle.
REQ-032 SHALL, without SERIAL_ADDSUB_OVF_EN, omit the ovf port and its register, with all other behaviour identical.

Verification (WIDTH=8, SERIAL_ADDSUB_OVF_EN defined)
REQ-033 SHALL pass: a=0x7F b=0x01 sub=0 -> result=0x80 cout=0 ovf=1, out_valid exactly 9 edges after accept.
REQ-034 SHALL pass: a=0xFF b=0x01 sub=0 -> result=0x00 cout=1 ovf=0.
REQ-035 SHALL pass: a=0x10 b=0x20 sub=1 -> result=0xF0 cout=0 (borrow) ovf=0; and a=0x80 b=0x01 sub=1 -> result=0x7F cout=1 ovf=1.
REQ-036 SHALL pass: out_ready held 0 for 5 cycles in DONE -> result/cout/ovf/out_valid unchanged throughout; in_ready=0 until one cycle after the out_ready handshake.
REQ-037 SHALL pass: rst pulsed on the 3rd RUN cycle -> out_valid stays 0 and in_ready=1 the next cycle; a new operation a=0x35 b=0x4A sub=0 then yields result=0x7F cout=0 ovf=0.
REQ-038 SHALL pass: in_valid toggled with changing a/b during RUN -> no effect on the in-flight result.
